u74hc_gate_bank: RTL and testbench
==================================

// Module: u74hc_gate_bank
// PURPOSE
//  Parametrised successor to the fixed hex-inverter package model. It is an N-channel
//  buffer/inverter bank with a per-channel propagation delay counted in clk ticks.
//  Delay is selectable: inertial (pulses shorter than DELAY are swallowed) or
//  transport (every pulse is reproduced DELAY ticks later). It provides per-channel
//  reset values and power-loss handling.
//  The bank sits between package pins in the board-level simulation, wherever 74HC04/07-class
//  parts are instantiated.
// PARAMETERS
//  CHANNELS  6           number of independent gates (1..32)
//  DELAY     9           propagation delay in clk ticks (1..64)
//  IC        {CHANNELS{1'b0}}  per-channel output value during reset/power loss
//  INVERT    1           1: y = ~a (74HC04 style); 0: y = a (buffer)
//  INERTIAL  1           1: inertial delay; 0: transport delay
// PORTS
//  clk      in   1         simulation tick clock
//  rst      in   1         reset, asynchronous, active-high
//  vcc      in   1         package supply pin; 0 = power lost
//  gnd      in   1         package ground pin; 1 = power lost
//  a        in   CHANNELS  gate inputs
//  y        out  CHANNELS  gate outputs (registered)
//  pending  out  CHANNELS  1 = a transition is in flight on that channel
// BEHAVIOUR
//  - vrst = rst | ~vcc | gnd. vrst acts as an asynchronous, active-high reset of all state.
//  - While vrst=1:
//    - y = IC, pending = 0, counters = 0, shift regs = IC.
//    - These values apply immediately, with no clk edge needed.
//  - Target per channel: t[i] = a[i] ^ INVERT. It is sampled only on posedge clk.
//  - INERTIAL=1, per channel:
//    - cnt[i] has width clog2(DELAY+1).
//    - Each edge with t!=y: if cnt==DELAY-1 then y<=t, cnt<=0; else cnt<=cnt+1.
//    - Each edge with t==y: cnt<=0. This is how glitches are cancelled.
//    - y changes exactly DELAY edges after the first edge that samples t!=y, provided t stays stable.
//    - pending[i] = (cnt[i]!=0) | (t[i]!=y[i]). This output is combinational.
//  - INERTIAL=0, per channel:
//    - sr[i] is a DELAY-bit shift register. Each edge: sr <= {sr[DELAY-2:0], t}.
//    - y[i] = sr[i][DELAY-1]. When DELAY=1, sr is a single flop.
//    - Every pulse of width >= 1 tick appears on y after DELAY edges, with unchanged width.
//    - pending[i] = (|(sr[i] ^ {DELAY{y[i]}})) | (t[i]!=y[i]).
//  - Channels are fully independent. Simultaneous toggles on several channels are each
//    handled separately.
//  - DELAY=1 in either mode: y is t registered by one edge.
//  - Reset or power loss mid-transition:
//    - In-flight state is discarded and y returns to IC.
//    - After release, the first edge starts a fresh full-DELAY evaluation.
//  - Release of vrst with t != IC: y reaches t DELAY edges later, and pending is high meanwhile.
//  - Counters never wrap. In inertial mode cnt saturates by design at DELAY-1 before clearing.
// TESTING
//  1. CHANNELS=6, IC=6'b101010, rst pulse with clk stopped -> y=6'b101010 at once, pending=0.
//  2. INERTIAL=1, DELAY=9, INVERT=1, a0 0->1 held -> y0 1->0 on 9th edge; pending0=1 until then.
//  3. INERTIAL=1, DELAY=9, a0 high for 8 edges then low -> y0 never changes; pending0 returns to 0.
//  4. INERTIAL=0, DELAY=4, 1-tick pulse on a1 -> 1-tick inverted pulse on y1 4 edges later;
//     a 3-pulse burst is reproduced exactly.
//  5. INERTIAL=1, DELAY=9, vcc=0 at cnt=5 -> y=IC async. With vcc=1 and a held, y flips 9 edges
//     after restore. Repeat with gnd=1.
//  6. a0 and a3 toggle 2 edges apart, INVERT=0, DELAY=3 -> y0 and y3 follow at +3 each;
//     other channels stay static.

Source files
------------

// File: rtl/u74hc_gate_bank.sv
// N-channel 74HC04/07-style buffer/inverter bank with a per-channel propagation delay
// in clk ticks, selectable inertial or transport delay, and supply-pin power-loss reset.
module u74hc_gate_bank #(
    parameter int unsigned         CHANNELS = 6,
    parameter int unsigned         DELAY    = 9,
    parameter logic [CHANNELS-1:0] IC       = '0,
    parameter bit                  INVERT   = 1'b1,
    parameter bit                  INERTIAL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vcc,
    input  logic                gnd,
    input  logic [CHANNELS-1:0] a,
    output logic [CHANNELS-1:0] y,
    output logic [CHANNELS-1:0] pending
);

    // Reset and loss of either supply pin clear all state without waiting for a clock edge.
    logic vrst;
    assign vrst = rst | ~vcc | gnd;

    logic [CHANNELS-1:0] t;
    logic [CHANNELS-1:0] busy;

    assign t       = a ^ {CHANNELS{INVERT}};
    assign pending = busy & {CHANNELS{~vrst}};

    if (INERTIAL) begin : g_inertial
        localparam int unsigned CW = $clog2(DELAY + 1);

        logic [CW-1:0]       cnt_q [CHANNELS];
        logic [CW-1:0]       cnt_d [CHANNELS];
        logic [CHANNELS-1:0] y_q;
        logic [CHANNELS-1:0] y_d;

        // A target that disagrees with the output must hold for DELAY consecutive edges;
        // any edge where it agrees again restarts the count, swallowing short glitches.
        always_comb begin
            y_d  = y_q;
            busy = '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_d[i] = '0;
                if (t[i] != y_q[i]) begin
                    if (cnt_q[i] == CW'(DELAY - 1)) begin
                        y_d[i] = t[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                busy[i] = (cnt_q[i] != '0) | (t[i] != y_q[i]);
            end
        end

        always_ff @(posedge clk or posedge vrst) begin
            if (vrst) begin
                y_q <= IC;
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                y_q <= y_d;
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end

        assign y = y_q;
    end else begin : g_transport
        logic [DELAY-1:0] sr_q [CHANNELS];
        logic [DELAY-1:0] sr_d [CHANNELS];

        // Shift-and-insert form also covers DELAY=1, where the register is a single flop.
        always_comb begin
            y    = '0;
            busy = '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                sr_d[i] = (sr_q[i] << 1) | DELAY'(t[i]);
                y[i]    = sr_q[i][DELAY-1];
                busy[i] = (|(sr_q[i] ^ {DELAY{sr_q[i][DELAY-1]}})) | (t[i] != sr_q[i][DELAY-1]);
            end
        end

        always_ff @(posedge clk or posedge vrst) begin
            if (vrst) begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    sr_q[i] <= {DELAY{IC[i]}};
                end
            end else begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    sr_q[i] <= sr_d[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_u74hc_gate_bank.sv
// Bench for u74hc_gate_bank: four differently configured instances checked against a
// history-based reference model, plus directed vector tables for the delay corner cases.
module tb_u74hc_gate_bank;

    localparam logic [5:0] IC0 = 6'b101010;  // DELAY 9, invert, inertial
    localparam logic [5:0] IC1 = 6'b010011;  // DELAY 4, invert, transport
    localparam logic [5:0] IC2 = 6'b000000;  // DELAY 3, buffer, inertial
    localparam logic [5:0] IC3 = 6'b111000;  // DELAY 1, buffer, transport

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst, vcc, gnd;
    logic [5:0] av [4];
    logic [5:0] yv [4];
    logic [5:0] pv [4];
    logic [5:0] y0, y1, y2, y3, p0, p1, p2, p3;
    logic       vrst_b;

    assign vrst_b = rst | ~vcc | gnd;
    assign yv[0] = y0; assign yv[1] = y1; assign yv[2] = y2; assign yv[3] = y3;
    assign pv[0] = p0; assign pv[1] = p1; assign pv[2] = p2; assign pv[3] = p3;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    u74hc_gate_bank #(.CHANNELS(6), .DELAY(9), .IC(IC0), .INVERT(1'b1), .INERTIAL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(av[0]), .y(y0), .pending(p0));
    u74hc_gate_bank #(.CHANNELS(6), .DELAY(4), .IC(IC1), .INVERT(1'b1), .INERTIAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(av[1]), .y(y1), .pending(p1));
    u74hc_gate_bank #(.CHANNELS(6), .DELAY(3), .IC(IC2), .INVERT(1'b0), .INERTIAL(1'b1)) dut2 (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(av[2]), .y(y2), .pending(p2));
    u74hc_gate_bank #(.CHANNELS(6), .DELAY(1), .IC(IC3), .INVERT(1'b0), .INERTIAL(1'b0)) dut3 (
        .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .a(av[3]), .y(y3), .pending(p3));

    int         dly [4];
    bit         inv [4];
    bit         inr [4];
    logic [5:0] icv [4];

    // Reference model: each channel remembers the targets it sampled on past edges.
    // Transport: output is the target sampled DELAY-1 edges before the latest one.
    // Inertial: output takes the target once it has disagreed for DELAY edges in a row.
    logic       ym   [4][6];
    int         run  [4][6];
    logic       hist [4][6][64];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 6; c++) begin
                ym[k][c]  = icv[k][c];
                run[k][c] = 0;
                for (int j = 0; j < 64; j++) hist[k][c][j] = icv[k][c];
            end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 6; c++) begin
                logic tt;
                tt = av[k][c] ^ inv[k];
                for (int j = 63; j > 0; j--) hist[k][c][j] = hist[k][c][j-1];
                hist[k][c][0] = tt;
                if (inr[k]) begin
                    run[k][c] = (tt != ym[k][c]) ? run[k][c] + 1 : 0;
                    if (run[k][c] == dly[k]) begin
                        ym[k][c]  = tt;
                        run[k][c] = 0;
                    end
                end else begin
                    ym[k][c] = hist[k][c][dly[k]-1];
                end
            end
    endtask

    function automatic logic [5:0] model_y(input int k);
        logic [5:0] v;
        for (int c = 0; c < 6; c++) v[c] = vrst_b ? icv[k][c] : ym[k][c];
        return v;
    endfunction

    function automatic logic [5:0] model_p(input int k);
        logic [5:0] v;
        v = '0;
        if (!vrst_b) begin
            for (int c = 0; c < 6; c++) begin
                logic tt;
                tt   = av[k][c] ^ inv[k];
                v[c] = (tt != ym[k][c]);
                if (inr[k]) v[c] = v[c] | (run[k][c] != 0);
                else
                    for (int j = 0; j < dly[k]; j++)
                        if (hist[k][c][j] != ym[k][c]) v[c] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s y%0d", tag, k), yv[k], model_y(k));
            chk($sformatf("%s pending%0d", tag, k), pv[k], model_p(k));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (vrst_b) model_reset();
        else model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    typedef struct {
        logic [5:0] a;
        logic [5:0] y;
        logic [5:0] p;
    } vec_t;

    vec_t       tv [18];
    logic [5:0] e6 [7];
    logic [11:0] pl;
    logic [5:0] e;
    int         n;

    initial begin
        dly = '{9, 4, 3, 1};
        inv = '{1'b1, 1'b1, 1'b0, 1'b0};
        inr = '{1'b1, 1'b0, 1'b1, 1'b0};
        icv = '{IC0, IC1, IC2, IC3};
        for (int k = 0; k < 4; k++) av[k] = icv[k] ^ {6{inv[k]}};

        // Instance 0, channel 1: a held for 9 edges flips y; held for only 8 it is swallowed.
        for (int i = 0; i < 8; i++) tv[i] = '{6'b010111, 6'b101010, 6'b000010};
        tv[8] = '{6'b010111, 6'b101000, 6'b000000};
        for (int i = 9; i < 17; i++) tv[i] = '{6'b010101, 6'b101000, 6'b000010};
        tv[17] = '{6'b010111, 6'b101000, 6'b000000};
        e6 = '{6'b000000, 6'b000000, 6'b000001, 6'b000001, 6'b001001, 6'b001001, 6'b001001};
        pl = 12'b1011_0100_0001;

        rst = 1'b0; vcc = 1'b1; gnd = 1'b0;

        // Reset with the clock stopped must load IC immediately.
        #2 rst = 1'b1;
        #1;
        chk("rst y0", y0, 6'b101010);
        chk("rst y1", y1, 6'b010011);
        chk("rst y3", y3, 6'b111000);
        chk("rst p0", p0, 6'b000000);
        chk("rst p1", p1, 6'b000000);
        #3 rst = 1'b0;
        #1;
        chk("post-rst y0", y0, 6'b101010);
        chk("post-rst p0", p0, 6'b000000);
        model_reset();
        #2 clk_en = 1'b1;

        for (int i = 0; i < 18; i++) begin
            av[0] = tv[i].a;
            tick("tbl");
            chk($sformatf("tbl[%0d] y", i), y0, tv[i].y);
            chk($sformatf("tbl[%0d] pending", i), p0, tv[i].p);
        end

        // Transport DELAY 4: a single-tick pulse and a burst reappear inverted 4 edges later.
        for (int k = 1; k <= 18; k++) begin
            av[1][1] = (k <= 12) ? pl[k-1] : 1'b0;
            tick("burst");
            e = IC1;
            if (k >= 4) e[1] = (k - 4 < 12) ? ~pl[k-4] : 1'b1;
            chk($sformatf("burst[%0d] y1", k), y1, e);
        end

        // Two channels toggled two edges apart each follow three edges later.
        for (int k = 0; k < 7; k++) begin
            av[2] = (k < 2) ? 6'b000001 : 6'b001001;
            tick("skew");
            chk($sformatf("skew[%0d] y2", k), y2, e6[k]);
        end

        // Power loss mid-transition, first through vcc then through gnd.
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b1;
            tick("pl-rst");
            rst = 1'b0;
            av[0] = 6'b010101;
            tick("pl-idle");
            av[0] = 6'b010111;
            for (int i = 0; i < 5; i++) tick("pl-count");
            #2;
            if (pass == 0) vcc = 1'b0;
            else gnd = 1'b1;
            model_reset();
            #1;
            chk($sformatf("loss%0d y0", pass), y0, 6'b101010);
            chk($sformatf("loss%0d p0", pass), p0, 6'b000000);
            @(negedge clk);
            tick("pl-held");
            vcc = 1'b1; gnd = 1'b0;
            n = 0;
            for (int i = 1; i <= 20 && n == 0; i++) begin
                tick("pl-restore");
                if (y0[1] == 1'b0) n = i;
            end
            chk($sformatf("loss%0d edges", pass), 6'(n), 6'd9);
        end

        // Randomized traffic with occasional reset and supply glitches.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < 6; c++)
                    if ($urandom_range(5) == 0) av[k][c] = ~av[k][c];
            r = int'($urandom_range(99));
            if (r == 0) rst = 1'b1;
            else if (r == 1) vcc = 1'b0;
            else if (r == 2) gnd = 1'b1;
            else if (vrst_b && $urandom_range(2) == 0) begin
                rst = 1'b0; vcc = 1'b1; gnd = 1'b0;
            end
            if (vrst_b) begin
                model_reset();
                #1 check_all("rnd-async");
            end
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
